rv32i_fetch: RTL and testbench

RV32I_FETCH -- requirements
Module: rv32i_fetch

---
 rtl/rv32i_fetch_if.sv | 25 ++
 rtl/rv32i_fetch.sv | 132 +++++++++++++
 tb/tb_rv32i_fetch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_if.sv
// Fetch-unit bus bundle: one memory read channel and one decode hand-off channel.
// Memory: mem_req_o/mem_addr_o hold until mem_ack_i; decode: an entry transfers when data_ready_o && decode_ready_i.
interface rv32i_fetch_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [ILEN-1:0] mem_data_i;
  logic            data_ready_o;
  logic            decode_ready_i;
  logic [ILEN-1:0] instruction_o;
  logic [XLEN-1:0] pc_data_o;

  modport master (
    output mem_req_o, mem_addr_o, data_ready_o, instruction_o, pc_data_o,
    input  mem_ack_i, mem_data_i, decode_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, data_ready_o, instruction_o, pc_data_o,
    output mem_ack_i, mem_data_i, decode_ready_i
  );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction prefetcher: one outstanding memory read feeding a {pc, instruction} queue,
// with flush/redirect that discards any in-flight response.
module rv32i_fetch #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] branch_target_i,
  rv32i_fetch_if.master   bus,
  output logic [1:0]      state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic            req_q;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [ILEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nxt;

  logic            push, pop;
  logic [XLEN-1:0] target, pc_plus4;

  always_comb begin
    target    = branch_target_i & ~XLEN'(3);
    pc_plus4  = fetch_pc + XLEN'(4);
    // Only a response to a live (non-discarded, non-flushed) request enters the queue.
    push      = (state == WAIT) && bus.mem_ack_i && !clear_i;
    pop       = (count != '0) && bus.decode_ready_i;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= bus.mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (clear_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_nxt;
      end

      case (state)
        IDLE: begin
          if (clear_i) begin
            fetch_pc <= target;
            req_addr <= target;
            req_q    <= 1'b1;
            state    <= WAIT;
          end else if (count < CW'(DEPTH)) begin
            req_addr <= fetch_pc;
            req_q    <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (clear_i) begin
            fetch_pc <= target;
            if (bus.mem_ack_i) begin
              req_addr <= target;
            end else begin
              // Request stays on the bus; its response must be swallowed.
              state <= DISCARD;
            end
          end else if (bus.mem_ack_i) begin
            fetch_pc <= pc_plus4;
            if (count_nxt < CW'(DEPTH)) begin
              req_addr <= pc_plus4;
            end else begin
              req_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (clear_i) fetch_pc <= target;
          if (bus.mem_ack_i) begin
            req_addr <= clear_i ? target : fetch_pc;
            state    <= WAIT;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_o     = req_q;
  assign bus.mem_addr_o    = req_addr;
  assign bus.data_ready_o  = (count != '0);
  assign bus.instruction_o = (count != '0) ? ins_mem[rd_ptr] : '0;
  assign bus.pc_data_o     = (count != '0) ? pc_mem[rd_ptr]  : '0;
  assign state_o           = state;
endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed cycle table, randomized run against a stream model,
// and a PC wrap-around check on a second instance.
module tb_rv32i_fetch;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, rst2, clr2;
  logic [31:0] tgt, tgt2;
  logic [1:0]  state_dbg, state_dbg2;

  rv32i_fetch_if #(.XLEN(XLEN), .ILEN(ILEN)) bus  ();
  rv32i_fetch_if #(.XLEN(XLEN), .ILEN(ILEN)) bus2 ();

  rv32i_fetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .branch_target_i(tgt), .bus(bus), .state_o(state_dbg)
  );

  rv32i_fetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RST_PC2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .clear_i(clr2), .branch_target_i(tgt2), .bus(bus2), .state_o(state_dbg2)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E77;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / reference stream ----------------
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst, clr;
    logic [31:0] tgt;
    logic        ack, drdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic [31:0] t, input logic a, input logic d,
                     input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.clr = c; v.tgt = t; v.ack = a; v.drdy = d;
    v.e_req = er; v.e_addr = ea; v.e_dv = ev; v.e_pc = ep;
    tbl.push_back(v);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input logic r, input logic c, input logic [31:0] t, input logic a,
                       input logic [31:0] dat, input logic d);
    rst = r; clr = c; tgt = t;
    bus.mem_ack_i = a; bus.mem_data_i = dat; bus.decode_ready_i = d;
  endtask

  initial begin
    logic [63:0] e;
    logic        p_have, p_rst, p_clr, p_req, p_ack, p_dv, p_drdy;
    logic [31:0] p_addr, p_pc, p_ins;
    logic        r_rst, r_clr, r_drdy, r_ack;
    logic [31:0] r_tgt, r_dat;
    int          lat_left;
    int          n_acc;
    int          k;
    logic [31:0] wrap_pc[3];

    rst = 1'b1; clr = 1'b0; tgt = '0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.decode_ready_i = 1'b0;
    rst2 = 1'b1; clr2 = 1'b0; tgt2 = '0;
    bus2.mem_ack_i = 1'b0; bus2.mem_data_i = '0; bus2.decode_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    //   rst clr tgt          ack drdy  req addr         dv pc
    add(0, 0, 32'h0,     0, 0,   0, 32'h0,     0, 32'h0);    // reset state, first request next
    add(0, 0, 32'h0,     1, 0,   1, 32'h0,     0, 32'h0);    // zero-latency acks fill queue
    add(0, 0, 32'h0,     1, 0,   1, 32'h4,     1, 32'h0);
    add(0, 0, 32'h0,     1, 0,   1, 32'h8,     1, 32'h0);
    add(0, 0, 32'h0,     1, 0,   1, 32'hC,     1, 32'h0);
    add(0, 0, 32'h0,     0, 0,   0, 32'h0,     1, 32'h0);    // full: request dropped
    add(0, 0, 32'h0,     1, 0,   0, 32'h0,     1, 32'h0);    // stray ack in IDLE
    add(0, 0, 32'h0,     0, 1,   0, 32'h0,     1, 32'h0);    // pop one
    add(0, 0, 32'h0,     0, 0,   0, 32'h0,     1, 32'h4);
    add(0, 0, 32'h0,     0, 1,   1, 32'h10,    1, 32'h4);    // resumes at 0x10
    add(0, 0, 32'h0,     1, 1,   1, 32'h10,    1, 32'h8);    // push + pop together
    add(0, 1, 32'h203,   1, 1,   1, 32'h14,    1, 32'hC);    // clear + ack + pop
    add(0, 0, 32'h0,     0, 1,   1, 32'h200,   0, 32'h0);
    add(0, 1, 32'h103,   0, 0,   1, 32'h200,   0, 32'h0);    // clear while waiting
    add(0, 0, 32'h0,     0, 0,   1, 32'h200,   0, 32'h0);
    add(0, 0, 32'h0,     0, 0,   1, 32'h200,   0, 32'h0);
    add(0, 0, 32'h0,     1, 0,   1, 32'h200,   0, 32'h0);    // stale ack dropped
    add(0, 0, 32'h0,     1, 0,   1, 32'h100,   0, 32'h0);
    add(0, 0, 32'h0,     0, 0,   1, 32'h104,   1, 32'h100);
    add(0, 1, 32'h40,    0, 0,   1, 32'h104,   1, 32'h100);  // held head, then clear
    add(0, 1, 32'h80,    0, 0,   1, 32'h104,   0, 32'h0);    // clear again while discarding
    add(0, 1, 32'h300,   1, 0,   1, 32'h104,   0, 32'h0);    // clear + ack while discarding
    add(0, 0, 32'h0,     0, 1,   1, 32'h300,   0, 32'h0);
    add(0, 0, 32'h0,     1, 1,   1, 32'h300,   0, 32'h0);
    add(0, 1, 32'h500,   0, 0,   1, 32'h304,   1, 32'h300);
    add(1, 0, 32'h0,     0, 0,   1, 32'h304,   0, 32'h0);    // reset while discarding
    add(0, 0, 32'h0,     1, 0,   0, 32'h0,     0, 32'h0);    // late ack after reset ignored
    add(0, 0, 32'h0,     0, 0,   1, 32'h0,     0, 32'h0);
    add(0, 0, 32'h0,     1, 0,   1, 32'h0,     0, 32'h0);
    add(0, 1, 32'h1000,  0, 0,   1, 32'h4,     1, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("tbl%0d_req", i), bus.mem_req_o, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), bus.mem_addr_o, tbl[i].e_addr);
      check($sformatf("tbl%0d_dv", i), bus.data_ready_o, tbl[i].e_dv);
      check($sformatf("tbl%0d_pc", i), bus.pc_data_o, tbl[i].e_pc);
      check($sformatf("tbl%0d_ins", i), bus.instruction_o, tbl[i].e_dv ? mem_word(tbl[i].e_pc) : 32'h0);
      drive(tbl[i].rst, tbl[i].clr, tbl[i].tgt, tbl[i].ack, mem_word(bus.mem_addr_o), tbl[i].drdy);
      step();
    end

    // ---------------- randomized run against the stream model ----------------
    exp_q.delete();
    next_pc = 32'h1000;
    refill();
    lat_left = -1;
    n_acc = 0;
    p_have = 1'b0;
    {p_rst, p_clr, p_req, p_ack, p_dv, p_drdy} = '0;
    p_addr = '0; p_pc = '0; p_ins = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (p_have) begin
        if (p_rst) begin
          check("rnd_rst_req", bus.mem_req_o, 1'b0);
          check("rnd_rst_dv", bus.data_ready_o, 1'b0);
        end else begin
          if (p_clr) check("rnd_clr_empty", bus.data_ready_o, 1'b0);
          if (p_req && !p_ack) begin
            check("rnd_req_hold", bus.mem_req_o, 1'b1);
            check("rnd_addr_hold", bus.mem_addr_o, p_addr);
          end
          if (p_dv && !p_drdy && !p_clr) begin
            check("rnd_dv_hold", bus.data_ready_o, 1'b1);
            check("rnd_pc_hold", bus.pc_data_o, p_pc);
            check("rnd_ins_hold", bus.instruction_o, p_ins);
          end
        end
      end
      if (bus.mem_req_o) check("rnd_align", {30'b0, bus.mem_addr_o[1:0]}, 32'h0);

      r_rst  = ($urandom_range(0, 299) == 0);
      r_clr  = ($urandom_range(0, 24) == 0);
      r_tgt  = $urandom;
      r_drdy = (((cyc / 500) % 2) == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);

      if (bus.data_ready_o && r_drdy && !r_clr && !r_rst) begin
        e = exp_q.pop_front();
        check("rnd_pc", bus.pc_data_o, e[63:32]);
        check("rnd_ins", bus.instruction_o, e[31:0]);
        n_acc++;
        refill();
      end

      r_ack = 1'b0;
      r_dat = $urandom;
      if (bus.mem_req_o) begin
        if (lat_left < 0) lat_left = $urandom_range(0, 3);
        if (lat_left == 0) begin
          r_ack = 1'b1;
          r_dat = mem_word(bus.mem_addr_o);
          lat_left = -1;
        end else begin
          lat_left--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        r_ack = 1'b1;
      end

      if (r_rst) begin
        lat_left = -1;
        exp_q.delete();
        next_pc = 32'h0;
        refill();
      end else if (r_clr) begin
        exp_q.delete();
        next_pc = r_tgt & ~32'h3;
        refill();
      end

      p_have = 1'b1;
      p_rst = r_rst; p_clr = r_clr; p_req = bus.mem_req_o; p_ack = r_ack;
      p_dv = bus.data_ready_o; p_drdy = r_drdy;
      p_addr = bus.mem_addr_o; p_pc = bus.pc_data_o; p_ins = bus.instruction_o;
      drive(r_rst, r_clr, r_tgt, r_ack, r_dat, r_drdy);
      step();
    end
    check("rnd_progress", (n_acc > 200) ? 32'd1 : 32'd0, 32'd1);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    // ---------------- PC wrap on the second instance ----------------
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    check("wrap_rst_dv", bus2.data_ready_o, 1'b0);
    check("wrap_rst_pc", bus2.pc_data_o, 32'h0);
    rst2 = 1'b0;
    bus2.decode_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      if (bus2.data_ready_o) begin
        check($sformatf("wrap_pc%0d", k), bus2.pc_data_o, wrap_pc[k]);
        check($sformatf("wrap_ins%0d", k), bus2.instruction_o, mem_word(wrap_pc[k]));
        k++;
      end
      bus2.mem_ack_i  = bus2.mem_req_o;
      bus2.mem_data_i = mem_word(bus2.mem_addr_o);
      step();
    end
    if (k < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL wrap_timeout: got %0d entries expected 3", k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
